// File: rtl/video_crop_pack.sv
// Capture-side window cropper / RGB packer feeding the frame_read_write write port.
// Define VIDEO_CROP_TESTPATTERN_EN to replace pixel data with three vertical colour bars.
module video_crop_pack #(
  parameter int unsigned H_OFFSET   = 7,
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned V_OFFSET   = 0,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned CNT_BITS   = 11,
  parameter int unsigned OUT_FMT    = 0,
  parameter int unsigned FRAME_SKIP = 0
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                in_h,
  input  logic                in_v,
  input  logic                in_f,
  input  logic [7:0]          in_r,
  input  logic [7:0]          in_g,
  input  logic [7:0]          in_b,
  output logic                write_en,
  output logic [15:0]         write_data,
  output logic                frame_start,
  output logic                frame_done,
  output logic                frame_err,
  output logic [CNT_BITS-1:0] pix_cnt,
  output logic [CNT_BITS-1:0] line_cnt
);

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int unsigned TOT_BITS  = $clog2(FRAME_PIX + 1) + 1;
  localparam int unsigned SKIP_BITS = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam int unsigned REL_BITS  = CNT_BITS + 1;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [TOT_BITS-1:0] TOT_MAX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_CAPTURE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  h_d;
  logic                  v_d;
  logic [SKIP_BITS-1:0]  skip_cnt;
  logic [TOT_BITS-1:0]   total;

  logic                  blank_c;
  logic                  h_rise_c;
  logic                  v_rise_c;
  logic                  v_fall_c;
  logic                  start_c;
  logic                  done_c;
  logic [REL_BITS-1:0]   rel_h_c;
  logic [REL_BITS-1:0]   rel_v_c;
  logic                  h_ok_c;
  logic                  v_ok_c;
  logic                  in_win_c;
  logic [15:0]           pixel_c;

  assign blank_c  = in_h | in_v | in_f;
  assign h_rise_c = in_h & ~h_d;
  assign v_rise_c = in_v & ~v_d;
  assign v_fall_c = ~in_v & v_d;
  assign start_c  = v_fall_c && (skip_cnt == '0);

  // Window test via extended subtraction: the top bit flags "before the offset".
  assign rel_h_c  = REL_BITS'(pix_cnt) - REL_BITS'(H_OFFSET);
  assign rel_v_c  = REL_BITS'(line_cnt) - REL_BITS'(V_OFFSET);
  assign h_ok_c   = !rel_h_c[CNT_BITS] && (rel_h_c[CNT_BITS-1:0] < CNT_BITS'(H_ACTIVE));
  assign v_ok_c   = !rel_v_c[CNT_BITS] && (rel_v_c[CNT_BITS-1:0] < CNT_BITS'(V_ACTIVE));
  assign in_win_c = !blank_c && (state == ST_CAPTURE) && h_ok_c && v_ok_c;

  // Frame capture state register
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame capture next state: a frame is only entered on a non-skipped in_v falling edge
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_c) begin
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (v_rise_c) begin
          state_nxt = ST_IDLE;
          done_c    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pixel/line position counters and blanking edge history
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      h_d      <= 1'b0;
      v_d      <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      h_d <= in_h;
      v_d <= in_v;
      if (blank_c) begin
        pix_cnt <= '0;
      end else if (pix_cnt != CNT_MAX) begin
        pix_cnt <= pix_cnt + CNT_BITS'(1);
      end
      if (in_v) begin
        line_cnt <= '0;
      end else if (h_rise_c && (line_cnt != CNT_MAX)) begin
        line_cnt <= line_cnt + CNT_BITS'(1);
      end
      if (v_fall_c) begin
        skip_cnt <= (skip_cnt == SKIP_BITS'(FRAME_SKIP)) ? '0 : skip_cnt + SKIP_BITS'(1);
      end
    end
  end

  // Per-frame write tally used for the frame_err size check
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      total <= '0;
    end else if (start_c) begin
      total <= '0;
    end else if (in_win_c && (total != TOT_MAX)) begin
      total <= total + TOT_BITS'(1);
    end
  end

`ifdef VIDEO_CROP_TESTPATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 3;
  localparam logic [15:0] C_RED   = (OUT_FMT == 0) ? 16'hF800 : 16'h7C00;
  localparam logic [15:0] C_GREEN = (OUT_FMT == 0) ? 16'h07E0 : 16'h03E0;
  localparam logic [15:0] C_BLUE  = 16'h001F;

  logic unused_pix_bits;
  assign unused_pix_bits = ^{in_r, in_g, in_b};

  // Three bars across the captured width; the last bar absorbs the remainder
  always_comb begin
    pixel_c = C_BLUE;
    if (rel_h_c[CNT_BITS-1:0] < CNT_BITS'(BAR_W)) begin
      pixel_c = C_RED;
    end else if (rel_h_c[CNT_BITS-1:0] < CNT_BITS'(2 * BAR_W)) begin
      pixel_c = C_GREEN;
    end
  end
`else
  logic unused_pix_bits;
  assign unused_pix_bits = ^{in_r[2:0], in_g[2:0], in_b[2:0]};

  assign pixel_c = (OUT_FMT == 0) ? {in_r[7:3], in_g[7:2], in_b[7:3]}
                                  : {1'b0, in_r[7:3], in_g[7:3], in_b[7:3]};
`endif

  // Registered write port and frame status
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      write_en    <= 1'b0;
      write_data  <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      write_en    <= in_win_c;
      frame_start <= start_c;
      frame_done  <= done_c;
      if (in_win_c) begin
        write_data <= pixel_c;
      end
      if (start_c) begin
        frame_err <= 1'b0;
      end else if (done_c) begin
        frame_err <= (total != TOT_BITS'(FRAME_PIX));
      end
    end
  end

endmodule

// File: tb/tb_video_crop_pack.sv
// Scoreboard bench for video_crop_pack: stimulus pushes expected writes/frame events,
// a negedge monitor pops and compares. A second instance runs with FRAME_SKIP=2.
module tb_video_crop_pack;

  localparam int H_OFF  = 7;
  localparam int H_ACT  = 480;
  localparam int V_OFF  = 1;
  localparam int V_ACT  = 4;
  localparam int CB     = 11;
  localparam int HB     = 16;
  localparam int LINE_W = 720;
  localparam int NLINES = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_b;
  logic          in_h;
  logic          in_v;
  logic          in_f;
  logic [7:0]    in_r;
  logic [7:0]    in_g;
  logic [7:0]    in_b;

  logic          we_a, fs_a, fd_a, fe_a;
  logic [15:0]   wd_a;
  logic [CB-1:0] pc_a, lc_a;
  logic          we_b, fs_b, fd_b, fe_b;
  logic [15:0]   wd_b;
  logic [CB-1:0] pc_b, lc_b;

  video_crop_pack #(
    .H_OFFSET(H_OFF), .H_ACTIVE(H_ACT), .V_OFFSET(V_OFF), .V_ACTIVE(V_ACT),
    .CNT_BITS(CB), .OUT_FMT(0), .FRAME_SKIP(0)
  ) dut_a (
    .pclk(clk), .rst(rst), .in_h(in_h), .in_v(in_v), .in_f(in_f),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .write_en(we_a), .write_data(wd_a), .frame_start(fs_a), .frame_done(fd_a),
    .frame_err(fe_a), .pix_cnt(pc_a), .line_cnt(lc_a)
  );

  video_crop_pack #(
    .H_OFFSET(H_OFF), .H_ACTIVE(H_ACT), .V_OFFSET(V_OFF), .V_ACTIVE(V_ACT),
    .CNT_BITS(CB), .OUT_FMT(0), .FRAME_SKIP(2)
  ) dut_b (
    .pclk(clk), .rst(rst_b), .in_h(in_h), .in_v(in_v), .in_f(in_f),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .write_en(we_b), .write_data(wd_b), .frame_start(fs_b), .frame_done(fd_b),
    .frame_err(fe_b), .pix_cnt(pc_b), .line_cnt(lc_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] cyc;
  } wr_t;

  typedef struct packed {
    logic        kind;  // 0 = frame_start, 1 = frame_done
    logic        err;
    logic [31:0] cyc;
  } ev_t;

  wr_t         wr_q[$];
  ev_t         ev_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  int          a_starts = 0, a_dones = 0, b_starts = 0, b_writes = 0;

  // Hand-computed RGB565 of the stimulus colours
  logic [7:0]  tbl_r[4]   = '{8'hFF, 8'h12, 8'h00, 8'hA5};
  logic [7:0]  tbl_g[4]   = '{8'h80, 8'h34, 8'hFF, 8'h5A};
  logic [7:0]  tbl_b[4]   = '{8'h00, 8'h56, 8'hFF, 8'hC3};
  logic [15:0] tbl_565[4] = '{16'hFC00, 16'h11AA, 16'h07FF, 16'hA2D8};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, exp, cyc);
    end
  endtask

`ifdef VIDEO_CROP_TESTPATTERN_EN
  function automatic logic [15:0] bar_colour(input int rel);
    if (rel < 160) return 16'hF800;
    if (rel < 320) return 16'h07E0;
    return 16'h001F;
  endfunction
`endif

  // Monitor for instance A: pops the write and frame-event queues
  logic        prev_we = 1'b0;
  logic [15:0] last_data = 16'h0;
  always @(negedge clk) begin : mon_a
    wr_t w;
    ev_t e;
    if (!rst) begin
      if (we_a) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("write_data", 32'(wd_a), 32'(w.data));
          check("write_cycle", cyc, w.cyc);
          last_data = w.data;
        end
      end else if (prev_we) begin
        check("write_data_hold", 32'(wd_a), 32'(last_data));
      end
      prev_we = we_a;
      if (fs_a || fd_a) begin
        if (fs_a) a_starts++;
        if (fd_a) a_dones++;
        if (ev_q.size() == 0) begin
          check("unexpected_frame_event", 32'd1, 32'd0);
        end else begin
          e = ev_q.pop_front();
          check("event_kind", 32'(fd_a), 32'(e.kind));
          check("event_cycle", cyc, e.cyc);
          check("frame_err", 32'(fe_a), 32'(e.err));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (fs_b) b_starts++;
    if (we_b) b_writes++;
  end

  // Reference frame state for instance A
  bit   a_active = 1'b0;
  int   a_writes = 0;
  logic v_prev   = 1'b1;

  task automatic set_v(input logic v);
    if (v_prev && !v) begin
      a_active = 1'b1;
      a_writes = 0;
      ev_q.push_back('{1'b0, 1'b0, cyc + 1});
    end else if (!v_prev && v) begin
      if (a_active) begin
        ev_q.push_back('{1'b1, (a_writes != H_ACT * V_ACT), cyc + 1});
        a_active = 1'b0;
      end
    end
    v_prev = v;
    in_v   = v;
  endtask

  task automatic do_line(input logic v, input int nact, input int lidx, input int colour,
                         input bit do_rst);
    logic [15:0] d;
    for (int c = 0; c < HB; c++) begin
      @(posedge clk); #1;
      in_h = 1'b1;
      if (c == 1) set_v(v);
      if (do_rst && c == 3) begin
        rst      = 1'b1;
        a_active = 1'b0;
      end
      if (do_rst && c == 5) rst = 1'b0;
    end
    in_r = tbl_r[colour];
    in_g = tbl_g[colour];
    in_b = tbl_b[colour];
    for (int p = 0; p < nact; p++) begin
      @(posedge clk); #1;
      in_h = 1'b0;
      if (!v && a_active && lidx >= V_OFF && lidx < V_OFF + V_ACT &&
          p >= H_OFF && p < H_OFF + H_ACT) begin
`ifdef VIDEO_CROP_TESTPATTERN_EN
        d = bar_colour(p - H_OFF);
`else
        d = tbl_565[colour];
`endif
        wr_q.push_back('{d, cyc + 1});
        a_writes++;
      end
    end
  endtask

  task automatic do_frame(input int fidx, input int short_line, input int rst_line);
    do_line(1'b1, LINE_W, 0, 0, 1'b0);
    for (int l = 0; l < NLINES; l++) begin
      do_line(1'b0, (l == short_line) ? 300 : LINE_W, l, (fidx + l) % 4, l == rst_line);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    rst_b = 1'b1;
    in_h  = 1'b1;
    in_v  = 1'b1;
    in_f  = 1'b0;
    in_r  = 8'h0;
    in_g  = 8'h0;
    in_b  = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_write_en", 32'(we_a), 32'd0);
    check("rst_write_data", 32'(wd_a), 32'd0);
    check("rst_frame_start", 32'(fs_a), 32'd0);
    check("rst_frame_done", 32'(fd_a), 32'd0);
    check("rst_frame_err", 32'(fe_a), 32'd0);
    check("rst_pix_cnt", 32'(pc_a), 32'd0);
    check("rst_line_cnt", 32'(lc_a), 32'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    rst_b = 1'b0;

    do_frame(0, -1, -1);  // full frame
    do_frame(1, 2, -1);   // one line truncated to 300 pixels
    do_frame(2, -1, -1);  // error clears on start
    do_frame(3, -1, 2);   // reset mid-frame
    do_frame(4, -1, -1);
    do_frame(5, -1, -1);
    do_line(1'b1, LINE_W, 0, 0, 1'b0);

    for (int i = 0; i < 20 && (wr_q.size() != 0 || ev_q.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    check("pending_writes", 32'(wr_q.size()), 32'd0);
    check("pending_events", 32'(ev_q.size()), 32'd0);
    check("a_frame_starts", 32'(a_starts), 32'd6);
    check("a_frame_dones", 32'(a_dones), 32'd5);
    check("b_frame_starts", 32'(b_starts), 32'd2);
    check("b_writes", 32'(b_writes), 32'd3840);
    check("a_frame_err_end", 32'(fe_a), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
